// File: rtl/mem_port_arbiter_pkg.sv
// +----------------------------------------------------------------------+
// | mem_port_arbiter_pkg: shared states and Func3 codes for the arbiter  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package mem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BUS_I  = 3'd1,
    ST_BUS_D  = 3'd2,
    ST_RESP_I = 3'd3,
    ST_RESP_D = 3'd4
  } arb_state_e;

  localparam int STREAK_W = 4;

  localparam logic [2:0] FUNC3_LB  = 3'b000;
  localparam logic [2:0] FUNC3_LH  = 3'b001;
  localparam logic [2:0] FUNC3_LW  = 3'b010;
  localparam logic [2:0] FUNC3_LBU = 3'b100;
  localparam logic [2:0] FUNC3_LHU = 3'b101;
  localparam logic [2:0] FUNC3_SB  = 3'b000;
  localparam logic [2:0] FUNC3_SH  = 3'b001;
  localparam logic [2:0] FUNC3_SW  = 3'b010;

  function automatic logic [STREAK_W-1:0] streak_next(
    input logic [STREAK_W-1:0] cur,
    input logic [STREAK_W-1:0] max
  );
    return (cur >= max) ? max : cur + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arb_grant.sv
// +----------------------------------------------------------------------+
// | mem_arb_grant: D-priority grant decision with bounded D streak       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_arb_grant
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic                i_req_i,
  input  logic                d_req_i,
  input  logic [STREAK_W-1:0] streak_i,
  output logic                grant_i_o,
  output logic                grant_d_o
);

  localparam logic [STREAK_W-1:0] MAX_STREAK = STREAK_W'(MAX_D_STREAK);

  // D wins unless fetch is waiting and D has already used up its streak.
  assign grant_d_o = d_req_i & (~i_req_i | (streak_i < MAX_STREAK));
  assign grant_i_o = i_req_i & ~grant_d_o;

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// +----------------------------------------------------------------------+
// | mem_port_arbiter: shares one memory port between fetch (I) and MEM   |
// | stage (D) requesters. Revision: 1.0                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              i_read_i,
  input  logic [ADDR_W-1:0] i_address_i,
  output logic [DATA_W-1:0] i_read_data_o,
  output logic              i_busywait_o,
  input  logic              d_read_i,
  input  logic              d_write_i,
  input  logic [ADDR_W-1:0] d_address_i,
  input  logic [DATA_W-1:0] d_write_data_i,
  input  logic [2:0]        d_func3_i,
  output logic [DATA_W-1:0] d_read_data_o,
  output logic              d_busywait_o,
  output logic              m_read_o,
  output logic              m_write_o,
  output logic [ADDR_W-1:0] m_address_o,
  output logic [DATA_W-1:0] m_write_data_o,
  output logic [2:0]        m_func3_o,
  input  logic [DATA_W-1:0] m_read_data_i,
  input  logic              m_busywait_i
);

  localparam logic [STREAK_W-1:0] MAX_STREAK = STREAK_W'(MAX_D_STREAK);

  arb_state_e          state_q;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                m_read_q, m_write_q;
  logic [ADDR_W-1:0]   m_address_q;
  logic [DATA_W-1:0]   m_write_data_q;
  logic [2:0]          m_func3_q;
  logic [DATA_W-1:0]   i_read_data_q, d_read_data_q;
  logic                i_req, d_req, grant_i, grant_d;

  assign i_req = i_read_i;
  assign d_req = d_read_i | d_write_i;

  mem_arb_grant #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_grant (
    .i_req_i  (i_req),
    .d_req_i  (d_req),
    .streak_i (streak_q),
    .grant_i_o(grant_i),
    .grant_d_o(grant_d)
  );

  // The streak only counts D wins that actually made fetch wait.
  always_comb begin
    streak_d = streak_q;
    if (state_q == ST_IDLE) begin
      if (!i_req)       streak_d = '0;
      else if (grant_d) streak_d = streak_next(streak_q, MAX_STREAK);
      else if (grant_i) streak_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_IDLE;
      streak_q       <= '0;
      m_read_q       <= 1'b0;
      m_write_q      <= 1'b0;
      m_address_q    <= '0;
      m_write_data_q <= '0;
      m_func3_q      <= '0;
      i_read_data_q  <= '0;
      d_read_data_q  <= '0;
    end else begin
      streak_q <= streak_d;
      case (state_q)
        ST_IDLE: begin
          if (grant_d) begin
            state_q        <= ST_BUS_D;
            m_write_q      <= d_write_i;
            m_read_q       <= d_read_i & ~d_write_i;
            m_address_q    <= d_address_i;
            m_write_data_q <= d_write_data_i;
            m_func3_q      <= d_func3_i;
          end else if (grant_i) begin
            state_q     <= ST_BUS_I;
            m_read_q    <= 1'b1;
            m_write_q   <= 1'b0;
            m_address_q <= i_address_i;
            m_func3_q   <= FUNC3_LW;
          end
        end
        ST_BUS_I, ST_BUS_D: begin
          if (!m_busywait_i) begin
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
            if (state_q == ST_BUS_I) begin
              i_read_data_q <= m_read_data_i;
              state_q       <= ST_RESP_I;
            end else begin
              if (m_read_q) d_read_data_q <= m_read_data_i;
              state_q <= ST_RESP_D;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign i_busywait_o   = i_req & (state_q != ST_RESP_I);
  assign d_busywait_o   = d_req & (state_q != ST_RESP_D);
  assign m_read_o       = m_read_q;
  assign m_write_o      = m_write_q;
  assign m_address_o    = m_address_q;
  assign m_write_data_o = m_write_data_q;
  assign m_func3_o      = m_func3_q;
  assign i_read_data_o  = i_read_data_q;
  assign d_read_data_o  = d_read_data_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_mem_port_arbiter: self-checking bench with a byte-array memory    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int MAX_D = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_read, d_read, d_write;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [2:0]  d_f3;
  logic [31:0] i_rdata, d_rdata;
  logic        i_bw, d_bw;
  logic        m_read, m_write, m_bw;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [2:0]  m_f3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(MAX_D)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .i_read_i(i_read), .i_address_i(i_addr), .i_read_data_o(i_rdata), .i_busywait_o(i_bw),
    .d_read_i(d_read), .d_write_i(d_write), .d_address_i(d_addr), .d_write_data_i(d_wdata),
    .d_func3_i(d_f3), .d_read_data_o(d_rdata), .d_busywait_o(d_bw),
    .m_read_o(m_read), .m_write_o(m_write), .m_address_o(m_addr), .m_write_data_o(m_wdata),
    .m_func3_o(m_f3), .m_read_data_i(m_rdata), .m_busywait_i(m_bw)
  );

  // Memory responder: holds busywait for mem_wait cycles of each strobe.
  logic [7:0] mem [256];
  int         mem_wait = 0;
  int         wcnt = 0;
  logic       m_strobe;
  logic [7:0] ma;
  assign m_strobe = m_read | m_write;
  assign m_bw     = m_strobe && (wcnt < mem_wait);
  assign ma       = m_addr[7:0];

  always @(posedge clk) begin
    if (!m_strobe) wcnt <= 0;
    else if (m_bw) wcnt <= wcnt + 1;
    else begin
      wcnt <= 0;
      if (m_write) begin
        mem[ma] <= m_wdata[7:0];
        if (m_f3[1:0] != 2'b00) mem[ma + 8'd1] <= m_wdata[15:8];
        if (m_f3[1:0] == 2'b10) begin
          mem[ma + 8'd2] <= m_wdata[23:16];
          mem[ma + 8'd3] <= m_wdata[31:24];
        end
      end
    end
  end

  always_comb begin
    m_rdata = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};
    case (m_f3)
      3'b000:  m_rdata = {{24{mem[ma][7]}}, mem[ma]};
      3'b001:  m_rdata = {{16{mem[ma + 8'd1][7]}}, mem[ma + 8'd1], mem[ma]};
      3'b100:  m_rdata = {24'd0, mem[ma]};
      3'b101:  m_rdata = {16'd0, mem[ma + 8'd1], mem[ma]};
      default: m_rdata = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};
    endcase
  end

  int grant_cnt = 0;
  logic prev_strobe = 1'b0;
  always @(posedge clk) begin
    prev_strobe <= m_strobe;
    if (m_strobe && !prev_strobe) grant_cnt <= grant_cnt + 1;
  end

  // Reference model: byte-addressed memory plus the last data each requester saw.
  byte unsigned refmem [256];
  logic [31:0]  model_d = '0;
  logic [31:0]  model_i = '0;

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int b0, h0;
    logic [31:0] w;
    w = 0;
    for (int j = 0; j < 4; j++) w = w | (32'(refmem[(a + j) & 255]) << (8 * j));
    b0 = int'(w[7:0]);
    h0 = int'(w[15:0]);
    case (f3)
      3'b000:  return (b0 >= 128) ? 32'(b0 - 256) : 32'(b0);
      3'b001:  return (h0 >= 32768) ? 32'(h0 - 65536) : 32'(h0);
      3'b100:  return 32'(b0);
      3'b101:  return 32'(h0);
      default: return w;
    endcase
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    for (int j = 0; j < n; j++) refmem[(a + j) & 255] = d[8*j +: 8];
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          is_i;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    int          nwait;
    logic [31:0] exp;
  } vec_t;

  // One complete access from IDLE: checks latency, strobes, latched fields, data.
  task automatic do_xact(input vec_t v, input string nm);
    int k, scyc;
    bit done;
    @(negedge clk);
    mem_wait = v.nwait;
    if (v.is_i) begin
      i_read = 1'b1; i_addr = v.addr;
    end else begin
      d_read = v.rd; d_write = v.wr; d_addr = v.addr; d_wdata = v.wdata; d_f3 = v.f3;
    end
    k = 0; scyc = 0; done = 1'b0;
    while (!done && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (m_strobe) begin
        scyc++;
        if (scyc == 1) begin
          chk({nm, " m_addr"}, m_addr, v.addr);
          chk({nm, " m_write"}, 32'(m_write), 32'(!v.is_i && v.wr));
          chk({nm, " m_read"}, 32'(m_read), 32'(v.is_i || (v.rd && !v.wr)));
          chk({nm, " m_func3"}, 32'(m_f3), v.is_i ? 32'(FUNC3_LW) : 32'(v.f3));
          if (!v.is_i && v.wr) chk({nm, " m_wdata"}, m_wdata, v.wdata);
        end
      end
      if (v.is_i ? !i_bw : !d_bw) done = 1'b1;
    end
    chk({nm, " latency"}, 32'(k), 32'(2 + v.nwait));
    chk({nm, " strobe cycles"}, 32'(scyc), 32'(1 + v.nwait));
    chk({nm, " rdata"}, v.is_i ? i_rdata : d_rdata, v.exp);
    if (v.is_i) model_i = v.exp;
    else if (!v.wr) model_d = v.exp;
    else ref_store(v.f3, v.addr, v.wdata);
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    @(posedge clk); #1;
    chk({nm, " idle strobes"}, 32'(m_strobe), 32'd0);
  endtask

  vec_t tbl [9];

  initial begin
    int k, nd, ng, c0;
    bit d_done, i_done, first, s, exp_i;
    vec_t v;

    for (int j = 0; j < 256; j++) begin mem[j] = 8'h00; refmem[j] = 8'h00; end

    tbl[0] = '{0, 0, 1, 32'h4,  32'h12345678, FUNC3_SW,  2, 32'h00000000};
    tbl[1] = '{0, 1, 0, 32'h4,  32'h0,        FUNC3_LW,  0, 32'h12345678};
    tbl[2] = '{0, 0, 1, 32'h10, 32'hDEADBEEF, FUNC3_SW,  1, 32'h12345678};
    tbl[3] = '{1, 1, 0, 32'h10, 32'h0,        FUNC3_LW,  0, 32'hDEADBEEF};
    tbl[4] = '{0, 1, 1, 32'h5,  32'hAA,       FUNC3_SB,  0, 32'h12345678};
    tbl[5] = '{0, 1, 0, 32'h5,  32'h0,        FUNC3_LB,  1, 32'hFFFFFFAA};
    tbl[6] = '{0, 1, 0, 32'h5,  32'h0,        FUNC3_LBU, 0, 32'h000000AA};
    tbl[7] = '{0, 1, 0, 32'h4,  32'h0,        FUNC3_LH,  3, 32'hFFFFAA78};
    tbl[8] = '{0, 1, 0, 32'h6,  32'h0,        FUNC3_LHU, 0, 32'h00001234};

    rst_n = 1'b0; i_read = 0; d_read = 0; d_write = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; d_f3 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset m_read", 32'(m_read), 0);
    chk("reset m_write", 32'(m_write), 0);
    chk("reset m_addr", m_addr, 0);
    chk("reset d_rdata", d_rdata, 0);
    chk("reset i_busywait", 32'(i_bw), 0);
    d_write = 1'b1;
    #1;
    chk("reset busywait follows req", 32'(d_bw), 1);
    d_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < 9; r++) do_xact(tbl[r], $sformatf("vec%0d", r));

    // Collision: both request in the same IDLE cycle, memory 1 busy cycle.
    @(negedge clk);
    mem_wait = 1; i_read = 1; i_addr = 32'h10; d_read = 1; d_addr = 32'h4; d_f3 = FUNC3_LW;
    k = 0; d_done = 0; i_done = 0; first = 1;
    while (!i_done && k < 30) begin
      @(posedge clk); #1;
      k++;
      if (first && m_strobe) begin chk("collide first addr", m_addr, 32'h4); first = 0; end
      if (!d_done && !d_bw) begin
        chk("collide D resp cycle", 32'(k), 3);
        chk("collide D data", d_rdata, ref_load(FUNC3_LW, 32'h4));
        chk("collide I still stalled", 32'(i_bw), 1);
        d_read = 0; d_done = 1;
      end
      if (!i_bw) begin
        chk("collide I resp cycle", 32'(k), 7);
        chk("collide I data", i_rdata, 32'hDEADBEEF);
        i_read = 0; i_done = 1;
      end
    end
    chk("collide completed", 32'(i_done), 1);
    @(posedge clk); #1;

    // Starvation bound: both held continuously, zero-wait memory.
    @(negedge clk);
    mem_wait = 0; d_read = 1; d_write = 0; d_addr = 32'h4; d_f3 = FUNC3_LW;
    i_read = 1; i_addr = 32'h10;
    nd = 0; ng = 0; s = 0;
    for (int c = 0; c < 80 && ng < 10; c++) begin
      @(posedge clk); #1;
      if (m_strobe && !s) begin
        exp_i = (nd >= MAX_D);
        chk($sformatf("starve grant%0d is I", ng), 32'(m_addr == 32'h10), 32'(exp_i));
        nd = exp_i ? 0 : nd + 1;
        ng++;
      end
      if (!i_bw) chk("starve fetch data", i_rdata, ref_load(FUNC3_LW, 32'h10));
      s = m_strobe;
    end
    chk("starve grant count", 32'(ng), 10);
    i_read = 0; d_read = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("starve drained", 32'(m_strobe), 0);

    // Asynchronous reset in the middle of a busy store.
    @(negedge clk);
    mem_wait = 5; d_write = 1; d_addr = 32'h20; d_wdata = 32'h55667788; d_f3 = FUNC3_SW;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst store active", 32'(m_write), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst m_write", 32'(m_write), 0);
    chk("midrst m_addr", m_addr, 0);
    chk("midrst m_wdata", m_wdata, 0);
    chk("midrst m_func3", 32'(m_f3), 0);
    chk("midrst d_rdata", d_rdata, 0);
    chk("midrst i_rdata", i_rdata, 0);
    chk("midrst d_busywait", 32'(d_bw), 1);
    @(posedge clk);
    @(negedge clk);
    mem_wait = 0; rst_n = 1'b1;
    k = 0; first = 1; d_done = 0;
    while (!d_done && k < 20) begin
      @(posedge clk); #1;
      k++;
      if (first && m_strobe) begin chk("restart addr", m_addr, 32'h20); first = 0; end
      if (!d_bw) d_done = 1;
    end
    chk("restart latency", 32'(k), 2);
    ref_store(FUNC3_SW, 32'h20, 32'h55667788);
    d_write = 0;
    @(posedge clk); #1;
    v = '{0, 1, 0, 32'h20, 32'h0, FUNC3_LW, 0, 32'h55667788};
    do_xact(v, "restart readback");

    // Random alternating I/D with zero-wait memory.
    c0 = grant_cnt;
    for (int r = 0; r < 20; r++) begin
      v.is_i = (r % 2 == 0);
      v.nwait = 0;
      v.wdata = $urandom;
      v.addr = 32'h40 + 32'($urandom_range(0, 63));
      if (v.is_i) begin
        v.rd = 1; v.wr = 0; v.f3 = FUNC3_LW;
      end else begin
        v.wr = 1'($urandom_range(0, 1));
        v.rd = ~v.wr;
        case ($urandom_range(0, 2))
          0:       v.f3 = v.wr ? FUNC3_SB : (($urandom_range(0, 1) != 0) ? FUNC3_LB : FUNC3_LBU);
          1:       v.f3 = v.wr ? FUNC3_SH : (($urandom_range(0, 1) != 0) ? FUNC3_LH : FUNC3_LHU);
          default: v.f3 = v.wr ? FUNC3_SW : FUNC3_LW;
        endcase
      end
      if (v.f3[1:0] == 2'b01) v.addr[0] = 1'b0;
      if (v.f3[1:0] == 2'b10) v.addr[1:0] = 2'b00;
      v.exp = v.is_i ? ref_load(FUNC3_LW, v.addr) : (v.wr ? model_d : ref_load(v.f3, v.addr));
      do_xact(v, $sformatf("rand%0d", r));
    end
    chk("rand grant count", 32'(grant_cnt - c0), 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
